apb_gpio_bridge: RTL and testbench
==================================

Name: apb_gpio_bridge

Overview:
APB3 slave front-end for the GPIO register block; it sits directly upstream of it. It converts APB transfers into the register block's gpio_addr / gpio_dat_i / gpio_we strobe interface and returns gpio_dat_o as PRDATA. It adds programmable wait states, decodes the address, raises PSLVERR on illegal accesses, and flags APB protocol violations.

Parameters:
ADDR_W, 8, width of paddr; the byte offset is paddr[7:0] and upper bits, if any, are ignored.
WAIT_STATES, 0, extra ACCESS cycles (0..15) inserted before pready.
MAX_OFFSET, 8'h24, highest mapped word offset (NEC register).

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
sys_rst  in  1  synchronous reset, active-low.
psel  in  1  APB select.
penable  in  1  APB enable.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_W  APB byte address.
pwdata  in  32  APB write data.
pready  out  1  transfer complete.
prdata  out  32  read data; valid only while pready=1.
pslverr  out  1  error response; valid only while pready=1.
prot_err  out  1  sticky protocol-violation flag.
gpio_addr  out  32  register address to the register block, zero-extended.
gpio_dat_i  out  32  write data to the register block.
gpio_we  out  1  one-cycle write strobe.
gpio_dat_o  in  32  read data from the register block; combinational on gpio_addr.

Behaviour:
- Reset (sys_rst=0 at an edge): state=IDLE, pready=0, prdata=0, pslverr=0, prot_err=0, gpio_addr=0, gpio_dat_i=0, gpio_we=0, wait counter=0. Reset overrides an in-flight transfer; no gpio_we is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if psel=1 and penable=0, latch paddr into gpio_addr, pwdata into gpio_dat_i, pwrite into a write flag, compute err, load cnt=WAIT_STATES, and go to ACCESS. If psel=1 and penable=1 in IDLE, set prot_err and stay in IDLE.
- ACCESS: requires psel=1 and penable=1 at every edge.
  - If either is 0: abort to IDLE, set prot_err, no pready, no gpio_we.
  - Else if cnt>0: cnt decrements.
  - Else (cnt=0): go to DONE and register the response:
    - pready=1.
    - pslverr=err.
    - prdata=gpio_dat_o for a read with err=0; otherwise 0.
    - gpio_we=1 for a write with err=0.
- DONE: holds for exactly one cycle, then returns to IDLE with pready=0, pslverr=0, gpio_we=0. prdata holds its value until the next completion.
- Latency: total transfer = 3 + WAIT_STATES cycles from the SETUP cycle to the completion cycle.
- The register block updates on the edge that ends DONE. Back-to-back: the next SETUP may occur in the cycle right after DONE.
- gpio_addr and gpio_dat_i are stable from the cycle after SETUP through DONE. They keep their last value while IDLE.
- err=1 if any of the following holds:
  - paddr[1:0] != 0.
  - paddr[7:0] > MAX_OFFSET.
  - the access is a write to offset 8'h00 (RGPIO_IN, read-only).
- A read of offset 8'h00 is legal.
- prot_err is cleared only by reset.

Test Plan:
- Write then read, WAIT_STATES=0: write 0x04 (OUT) with 32'habcd_ef12. Required: gpio_we high exactly 1 cycle, gpio_addr=0x04, gpio_dat_i=32'habcd_ef12, pready on cycle 3 with pslverr=0. A following read of 0x04 returns prdata=32'habcd_ef12.
- Wait states, WAIT_STATES=3: read of 0x08 completes on cycle 6. pready stays 0 for cycles 2-5. prdata equals gpio_dat_o sampled at the final ACCESS edge.
- Error decode:
  - write 0x00 -> pslverr=1, gpio_we never asserted.
  - read 0x26 (misaligned) -> pslverr=1, prdata=0.
  - read 0x28 (beyond MAX_OFFSET) -> pslverr=1, prdata=0.
  - read 0x24 -> pslverr=0.
- Protocol abort: drop penable mid-ACCESS with WAIT_STATES=2. Required: return to IDLE, prot_err=1, no pready, no gpio_we. The next legal transfer completes normally with prot_err still 1.
- Reset mid-transfer: assert sys_rst=0 during ACCESS of a write. Required: all outputs are 0 after the edge and gpio_we is never pulsed. After release, a write to 0x14 (AUX) with 32'hffff_ffff succeeds.
- Back-to-back: writes to 0x08, 0x0C and 0x10 with no idle cycles between them. Required: 3 gpio_we pulses spaced 3 cycles apart, each with the correct gpio_addr and data.

Source files
------------

// File: rtl/apb_gpio_bridge.sv
// APB3 slave front-end for the GPIO register block: programmable wait states,
// address decode with PSLVERR, and a sticky APB protocol-violation flag.
module apb_gpio_bridge #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [7:0]  MAX_OFFSET  = 8'h24
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic              prot_err,
    output logic [31:0]       gpio_addr,
    output logic [31:0]       gpio_dat_i,
    output logic              gpio_we,
    input  logic [31:0]       gpio_dat_o,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_err;
    logic        r_pready;
    logic [31:0] r_prdata;
    logic        r_pslverr;
    logic        r_prot_err;
    logic [31:0] r_gpio_addr;
    logic [31:0] r_gpio_dat_i;
    logic        r_gpio_we;

    state_t      w_state_nx;
    logic [3:0]  w_cnt_nx;
    logic        w_write_nx;
    logic        w_err_nx;
    logic        w_pready_nx;
    logic [31:0] w_prdata_nx;
    logic        w_pslverr_nx;
    logic        w_prot_err_nx;
    logic [31:0] w_gpio_addr_nx;
    logic [31:0] w_gpio_dat_i_nx;
    logic        w_gpio_we_nx;

    logic [7:0]  w_off;
    logic        w_setup_err;

    // Only the low byte is decoded; RGPIO_IN at offset 0 is read-only.
    assign w_off       = paddr[7:0];
    assign w_setup_err = (w_off[1:0] != 2'b00) || (w_off > MAX_OFFSET) ||
                         (pwrite && (w_off == 8'h00));

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_write_nx      = r_write;
        w_err_nx        = r_err;
        w_pready_nx     = 1'b0;
        w_prdata_nx     = r_prdata;
        w_pslverr_nx    = 1'b0;
        w_prot_err_nx   = r_prot_err;
        w_gpio_addr_nx  = r_gpio_addr;
        w_gpio_dat_i_nx = r_gpio_dat_i;
        w_gpio_we_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (psel && !penable) begin
                    w_gpio_addr_nx  = {24'h0, w_off};
                    w_gpio_dat_i_nx = pwdata;
                    w_write_nx      = pwrite;
                    w_err_nx        = w_setup_err;
                    w_cnt_nx        = LP_WS;
                    w_state_nx      = S_ACCESS;
                end else if (psel && penable) begin
                    w_prot_err_nx = 1'b1;
                end
            end
            S_ACCESS: begin
                if (!(psel && penable)) begin
                    w_prot_err_nx = 1'b1;
                    w_state_nx    = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    // gpio_dat_o is combinational on r_gpio_addr, so it is valid here.
                    w_state_nx   = S_DONE;
                    w_pready_nx  = 1'b1;
                    w_pslverr_nx = r_err;
                    w_prdata_nx  = (!r_write && !r_err) ? gpio_dat_o : 32'h0;
                    w_gpio_we_nx = r_write && !r_err;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_pready     <= 1'b0;
            r_prdata     <= 32'h0;
            r_pslverr    <= 1'b0;
            r_prot_err   <= 1'b0;
            r_gpio_addr  <= 32'h0;
            r_gpio_dat_i <= 32'h0;
            r_gpio_we    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_write      <= w_write_nx;
            r_err        <= w_err_nx;
            r_pready     <= w_pready_nx;
            r_prdata     <= w_prdata_nx;
            r_pslverr    <= w_pslverr_nx;
            r_prot_err   <= w_prot_err_nx;
            r_gpio_addr  <= w_gpio_addr_nx;
            r_gpio_dat_i <= w_gpio_dat_i_nx;
            r_gpio_we    <= w_gpio_we_nx;
        end
    end

    assign pready     = r_pready;
    assign prdata     = r_prdata;
    assign pslverr    = r_pslverr;
    assign prot_err   = r_prot_err;
    assign gpio_addr  = r_gpio_addr;
    assign gpio_dat_i = r_gpio_dat_i;
    assign gpio_we    = r_gpio_we;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_apb_gpio_bridge.sv
// Bench for apb_gpio_bridge: three instances (0, 3 and 2 wait states) share one
// APB bus with private psel lines; a register-block model sits behind each.
module tb_apb_gpio_bridge;

  localparam int NI = 3;

  // Valid/ready: a response is accepted in the single cycle pready is high;
  // gpio_we is a one-cycle strobe that the register model takes on that edge.

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] psel;
  logic penable;
  logic pwrite;
  logic [7:0] paddr;
  logic [31:0] pwdata;
  logic [NI-1:0] pready;
  logic [NI-1:0] pslverr;
  logic [NI-1:0] prot_err;
  logic [NI-1:0] gpio_we;
  logic [31:0] prdata [NI];
  logic [31:0] gpio_addr [NI];
  logic [31:0] gpio_dat_i [NI];
  logic [31:0] gpio_dat_o [NI];
  logic [1:0] dbg_state [NI];

  logic [31:0] mem [NI][16];
  bit [15:0] wr_v [NI];

  logic [15:0] cyc = 16'd0;
  int checks = 0;
  int errors = 0;

  // {inst[1:0], pslverr, prdata[31:0], completion cycle[15:0]}
  logic [50:0] resp_q[$];
  // {inst[1:0], gpio_addr[31:0], gpio_dat_i[31:0], strobe cycle[15:0]}
  logic [81:0] we_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  function automatic int ws_of(input int g);
    case (g)
      0: return 0;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] init_val(input int g, input logic [3:0] idx);
    return 32'hC0DE_0000 + 32'(g) * 32'd256 + 32'(idx);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_gpio_bridge #(
      .ADDR_W(8),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2)),
      .MAX_OFFSET(8'h24)
    ) u_dut (
      .sys_clk(clk),
      .sys_rst(rst_n),
      .psel(psel[g]),
      .penable(penable),
      .pwrite(pwrite),
      .paddr(paddr),
      .pwdata(pwdata),
      .pready(pready[g]),
      .prdata(prdata[g]),
      .pslverr(pslverr[g]),
      .prot_err(prot_err[g]),
      .gpio_addr(gpio_addr[g]),
      .gpio_dat_i(gpio_dat_i[g]),
      .gpio_we(gpio_we[g]),
      .gpio_dat_o(gpio_dat_o[g]),
      .dbg_state(dbg_state[g])
    );
    assign gpio_dat_o[g] = wr_v[g][gpio_addr[g][5:2]] ? mem[g][gpio_addr[g][5:2]]
                                                       : init_val(g, gpio_addr[g][5:2]);
  end

  // Register block model: unwritten words read back their init_val pattern.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (gpio_we[g]) begin
        mem[g][gpio_addr[g][5:2]] <= gpio_dat_i[g];
        wr_v[g][gpio_addr[g][5:2]] <= 1'b1;
      end
    end
  end

  // Monitor: every pready / gpio_we must match the head of its queue.
  always @(negedge clk) begin : mon
    logic [50:0] r_act;
    logic [50:0] r_exp;
    logic [81:0] w_act;
    logic [81:0] w_exp;
    for (int g = 0; g < NI; g++) begin
      if (pready[g]) begin
        r_act = {2'(g), pslverr[g], prdata[g], cyc};
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected inst=%0d got=%h want=none", g, r_act);
        end else begin
          r_exp = resp_q.pop_front();
          if (r_act !== r_exp) begin
            errors++;
            $display("FAIL resp inst=%0d got=%h want=%h", g, r_act, r_exp);
          end
        end
      end
      if (gpio_we[g]) begin
        w_act = {2'(g), gpio_addr[g], gpio_dat_i[g], cyc};
        checks++;
        if (we_q.size() == 0) begin
          errors++;
          $display("FAIL we_unexpected inst=%0d got=%h want=none", g, w_act);
        end else begin
          w_exp = we_q.pop_front();
          if (w_act !== w_exp) begin
            errors++;
            $display("FAIL we inst=%0d got=%h want=%h", g, w_act, w_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full APB transfer; returns one cycle after DONE so a call may follow at once.
  task automatic apb_xfer(input int g, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [31:0] exp_rdata);
    logic [15:0] done_cyc;
    int n;
    psel = '0;
    psel[g] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = wdata;
    done_cyc = cyc + 16'(2 + ws_of(g));
    resp_q.push_back({2'(g), exp_err, (exp_err || wr) ? 32'h0 : exp_rdata, done_cyc});
    if (wr && !exp_err) we_q.push_back({2'(g), {24'h0, addr}, wdata, done_cyc});
    @(posedge clk);
    #1;
    penable = 1'b1;
    n = 0;
    while (!pready[g] && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL xfer_timeout inst=%0d got=no_pready want=pready", g);
    end
    @(posedge clk);
    #1;
    psel = '0;
    penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    psel = '0;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = 8'h0;
    pwdata = 32'h0;
    idle(3);
    chk("rst_pready", 32'(pready[0]), 32'h0);
    chk("rst_pslverr", 32'(pslverr[0]), 32'h0);
    chk("rst_prot_err", 32'(prot_err[0]), 32'h0);
    chk("rst_gpio_we", 32'(gpio_we[0]), 32'h0);
    chk("rst_prdata", prdata[0], 32'h0);
    chk("rst_gpio_addr", gpio_addr[0], 32'h0);
    chk("rst_gpio_dat_i", gpio_dat_i[0], 32'h0);
    chk("rst_state", 32'(dbg_state[0]), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Zero wait states: write then read back OUT.
    apb_xfer(0, 1'b1, 8'h04, 32'habcd_ef12, 1'b0, 32'h0);
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 1'b0, 32'habcd_ef12);
    idle(2);

    // Decode: RGPIO_IN readable but not writable, misaligned, out of range, top word.
    apb_xfer(0, 1'b0, 8'h00, 32'h0, 1'b0, init_val(0, 4'd0));
    apb_xfer(0, 1'b1, 8'h00, 32'h1234_5678, 1'b1, 32'h0);
    apb_xfer(0, 1'b0, 8'h26, 32'h0, 1'b1, 32'h0);
    apb_xfer(0, 1'b0, 8'h28, 32'h0, 1'b1, 32'h0);
    apb_xfer(0, 1'b0, 8'h24, 32'h0, 1'b0, init_val(0, 4'd9));
    apb_xfer(0, 1'b0, 8'h00, 32'h0, 1'b0, init_val(0, 4'd0));
    chk("decode_prot_err", 32'(prot_err[0]), 32'h0);
    idle(2);

    // Back-to-back writes: strobes land exactly three cycles apart.
    apb_xfer(0, 1'b1, 8'h08, 32'h1111_1111, 1'b0, 32'h0);
    apb_xfer(0, 1'b1, 8'h0C, 32'h2222_2222, 1'b0, 32'h0);
    apb_xfer(0, 1'b1, 8'h10, 32'h3333_3333, 1'b0, 32'h0);
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 1'b0, 32'h2222_2222);
    idle(2);

    // Three wait states.
    apb_xfer(1, 1'b0, 8'h08, 32'h0, 1'b0, init_val(1, 4'd2));
    idle(2);

    // Protocol abort: penable dropped on the middle ACCESS cycle of a write.
    psel = 3'b100;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h04;
    pwdata = 32'hdead_beef;
    idle(1);
    penable = 1'b1;
    idle(1);
    penable = 1'b0;
    idle(1);
    psel = '0;
    chk("abort_prot_err", 32'(prot_err[2]), 32'h1);
    chk("abort_state", 32'(dbg_state[2]), 32'h0);
    idle(1);
    apb_xfer(2, 1'b0, 8'h04, 32'h0, 1'b0, init_val(2, 4'd1));
    chk("abort_prot_err_sticky", 32'(prot_err[2]), 32'h1);
    idle(2);

    // Reset in the middle of a write on the 3-wait-state instance.
    psel = 3'b010;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h04;
    pwdata = 32'h5555_aaaa;
    idle(1);
    penable = 1'b1;
    idle(1);
    rst_n = 1'b0;
    idle(1);
    chk("midrst_pready", 32'(pready[1]), 32'h0);
    chk("midrst_prdata", prdata[1], 32'h0);
    chk("midrst_gpio_addr", gpio_addr[1], 32'h0);
    chk("midrst_gpio_dat_i", gpio_dat_i[1], 32'h0);
    chk("midrst_state", 32'(dbg_state[1]), 32'h0);
    chk("midrst_prot_err2", 32'(prot_err[2]), 32'h0);
    rst_n = 1'b1;
    psel = '0;
    penable = 1'b0;
    idle(1);
    apb_xfer(1, 1'b1, 8'h14, 32'hffff_ffff, 1'b0, 32'h0);
    apb_xfer(1, 1'b0, 8'h14, 32'h0, 1'b0, 32'hffff_ffff);
    apb_xfer(1, 1'b0, 8'h04, 32'h0, 1'b0, init_val(1, 4'd1));
    idle(4);

    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
    chk("we_q_drained", 32'(we_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
